// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the data-memory bus: round-robin grant, window decode, one access in flight.
// Define ARB_FIXED_PRIO_EN to make M0 win every tie (round-robin state removed).
module mem_bus_arbiter #(
    parameter logic [31:0] DM_LSA     = 32'h0000_0000,
    parameter logic [31:0] DM_MSA     = 32'h0000_2FFF,
    parameter logic [31:0] TIMER0_LSA = 32'h0000_7F00,
    parameter logic [31:0] TIMER0_MSA = 32'h0000_7F0B,
    parameter logic [31:0] TIMER1_LSA = 32'h0000_7F10,
    parameter logic [31:0] TIMER1_MSA = 32'h0000_7F1B,
    parameter logic [31:0] INT_LSA    = 32'h0000_7F20,
    parameter logic [31:0] INT_MSA    = 32'h0000_7F23
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic [3:0]  s_sel,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_be,
    input  logic [31:0] dm_rdata,
    input  logic [31:0] tc0_rdata,
    input  logic [31:0] tc1_rdata,
    input  logic [31:0] int_rdata,
    output logic [1:0]  state_dbg
);

    // Handshake: a master raises mN_req with stable addr/wdata/be and holds it
    // until the one-cycle mN_ack; mN_err and mN_rdata are valid only with mN_ack.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state, state_next;

    logic        any_req;
    logic        grant_m1;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [3:0]  win_be;
    logic [3:0]  dec;
    logic        be_shape_ok;
    logic        timer_hit;
    logic        count_write;
    logic        legal;
    logic        grant_q;
    logic        err_q;
    logic [31:0] slave_rdata;

    function automatic logic in_win(input logic [31:0] a, input logic [31:0] lo,
                                    input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    assign any_req = m0_req | m1_req;

`ifdef ARB_FIXED_PRIO_EN
    always_comb grant_m1 = m1_req & ~m0_req;
`else
    logic last_m1;

    // On a tie the master that did not win last time is granted.
    always_comb begin
        if (m0_req && m1_req) grant_m1 = ~last_m1;
        else                  grant_m1 = m1_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         last_m1 <= 1'b1;
        else if (state == IDLE && any_req) last_m1 <= grant_m1;
    end
`endif

    assign win_addr  = grant_m1 ? m1_addr  : m0_addr;
    assign win_wdata = grant_m1 ? m1_wdata : m0_wdata;
    assign win_be    = grant_m1 ? m1_be    : m0_be;

    always_comb begin
        dec[0] = in_win(win_addr, DM_LSA, DM_MSA);
        dec[1] = in_win(win_addr, TIMER0_LSA, TIMER0_MSA);
        dec[2] = in_win(win_addr, TIMER1_LSA, TIMER1_MSA);
        dec[3] = in_win(win_addr, INT_LSA, INT_MSA);
    end

    always_comb begin
        case (win_be)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_shape_ok = 1'b1;
            default:                   be_shape_ok = 1'b0;
        endcase
    end

    // Timers are word-only and their count register (offset 8..B) is read-only.
    assign timer_hit   = dec[1] | dec[2];
    assign count_write = (win_be != 4'b0000) &&
                         ((dec[1] && (win_addr - TIMER0_LSA) >= 32'd8) ||
                          (dec[2] && (win_addr - TIMER1_LSA) >= 32'd8));
    assign legal = (|dec) && be_shape_ok && !count_write &&
                   (!timer_hit || win_be == 4'b0000 || win_be == 4'b1111);

    always_comb begin
        case (s_sel)
            4'b0001: slave_rdata = dm_rdata;
            4'b0010: slave_rdata = tc0_rdata;
            4'b0100: slave_rdata = tc1_rdata;
            4'b1000: slave_rdata = int_rdata;
            default: slave_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign state_dbg = state;

    // Slave-side outputs are registered so s_sel is high for exactly the ISSUE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_sel    <= 4'b0;
            s_addr   <= 32'h0;
            s_wdata  <= 32'h0;
            s_be     <= 4'b0;
            m0_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= 32'h0;
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= 32'h0;
            grant_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            s_sel  <= 4'b0;
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= grant_m1;
                        err_q   <= ~legal;
                        s_addr  <= win_addr;
                        s_wdata <= win_wdata;
                        s_be    <= win_be;
                        s_sel   <= legal ? dec : 4'b0;
                    end
                end
                ISSUE: begin
                    // An illegal access has s_sel=0, so the mux already yields 0.
                    if (grant_q) begin
                        m1_ack   <= 1'b1;
                        m1_err   <= err_q;
                        m1_rdata <= (s_be == 4'b0000) ? slave_rdata : 32'h0;
                    end else begin
                        m0_ack   <= 1'b1;
                        m0_err   <= err_q;
                        m0_rdata <= (s_be == 4'b0000) ? slave_rdata : 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
